// File: rtl/sync_stream_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// sync_stream_controller - pipelined FIFO-to-homography query issuer and
// in-order return aligner with mismatch, spurious and timeout detection.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sync_stream_controller #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int CW      = 8,
  parameter int RW      = 5,
  parameter int GW      = 6,
  parameter int BW      = 5,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                         clk_25,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr_err,
  input  logic [XW+YW+3*CW-1:0]        q,
  input  logic                         rdempty,
  output logic                         rdreq,
  output logic [XW-1:0]                query_x,
  output logic [YW-1:0]                query_y,
  output logic                         start,
  input  logic                         ready,
  input  logic [XW-1:0]                return_x,
  input  logic [YW-1:0]                return_y,
  input  logic [RW-1:0]                r,
  input  logic [GW-1:0]                g,
  input  logic [BW-1:0]                b,
  output logic                         val,
  output logic [XW-1:0]                sync_x,
  output logic [YW-1:0]                sync_y,
  output logic [RW-1:0]                dvi_r,
  output logic [GW-1:0]                dvi_g,
  output logic [BW-1:0]                dvi_b,
  output logic [RW-1:0]                ccd_r,
  output logic [GW-1:0]                ccd_g,
  output logic [BW-1:0]                ccd_b,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         err_mismatch,
  output logic                         err_spurious,
  output logic                         err_timeout,
  output logic [15:0]                  mismatch_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  // FIFO record field extraction: {x, y, r, g, b}
  logic [CW-1:0] rec_b;
  logic [CW-1:0] rec_g;
  logic [CW-1:0] rec_r;
  logic [YW-1:0] rec_y;
  logic [XW-1:0] rec_x;

  assign rec_b = q[CW-1:0];
  assign rec_g = q[2*CW-1:CW];
  assign rec_r = q[3*CW-1:2*CW];
  assign rec_y = q[3*CW+YW-1:3*CW];
  assign rec_x = q[3*CW+YW+XW-1:3*CW+YW];

  // Only the channel MSBs are kept; the reduction marks the rest as consumed.
  logic unused_q;
  assign unused_q = ^q;

  logic [XW-1:0] pend_x [DEPTH];
  logic [YW-1:0] pend_y [DEPTH];
  logic [RW-1:0] pend_r [DEPTH];
  logic [GW-1:0] pend_g [DEPTH];
  logic [BW-1:0] pend_b [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [TW-1:0] tcnt;

  logic flush;
  logic has_out;
  logic issue;
  logic pop;
  logic spurious;
  logic mismatch;
  logic [15:0] cnt_base;

  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;

  assign head_x   = pend_x[rptr];
  assign head_y   = pend_y[rptr];

  assign flush    = (tcnt == TW'(TIMEOUT));
  assign has_out  = (outstanding != '0);
  assign issue    = ~rst & en & ~rdempty & (outstanding < OW'(DEPTH)) & ~flush;
  assign rdreq    = issue;
  assign pop      = ready & has_out & ~flush;
  assign spurious = ready & ~has_out & ~flush;
  assign mismatch = pop & ((head_x != return_x) | (head_y != return_y));
  assign cnt_base = clr_err ? 16'h0000 : mismatch_cnt;

  always_ff @(posedge clk_25) begin
    if (issue) begin
      pend_x[wptr] <= rec_x;
      pend_y[wptr] <= rec_y;
      pend_r[wptr] <= rec_r[CW-1:CW-RW];
      pend_g[wptr] <= rec_g[CW-1:CW-GW];
      pend_b[wptr] <= rec_b[CW-1:CW-BW];
    end
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      start        <= 1'b0;
      query_x      <= '0;
      query_y      <= '0;
      val          <= 1'b0;
      sync_x       <= '0;
      sync_y       <= '0;
      dvi_r        <= '0;
      dvi_g        <= '0;
      dvi_b        <= '0;
      ccd_r        <= '0;
      ccd_g        <= '0;
      ccd_b        <= '0;
      outstanding  <= '0;
      wptr         <= '0;
      rptr         <= '0;
      tcnt         <= '0;
      err_mismatch <= 1'b0;
      err_spurious <= 1'b0;
      err_timeout  <= 1'b0;
      mismatch_cnt <= 16'h0000;
    end else begin
      start <= issue;
      if (issue) begin
        query_x <= rec_x;
        query_y <= rec_y;
      end

      val <= pop;
      if (pop) begin
        sync_x <= return_x;
        sync_y <= return_y;
        ccd_r  <= r;
        ccd_g  <= g;
        ccd_b  <= b;
        dvi_r  <= pend_r[rptr];
        dvi_g  <= pend_g[rptr];
        dvi_b  <= pend_b[rptr];
      end

      if (flush) begin
        wptr        <= '0;
        rptr        <= '0;
        outstanding <= '0;
      end else begin
        if (issue) wptr <= wptr + PW'(1);
        if (pop)   rptr <= rptr + PW'(1);
        if (issue && !pop)      outstanding <= outstanding + OW'(1);
        else if (pop && !issue) outstanding <= outstanding - OW'(1);
      end

      // Counts idle cycles while queries are pending; any return restarts it.
      if (flush || ready || !has_out) tcnt <= '0;
      else                            tcnt <= tcnt + TW'(1);

      if (mismatch)     err_mismatch <= 1'b1;
      else if (clr_err) err_mismatch <= 1'b0;

      if (spurious)     err_spurious <= 1'b1;
      else if (clr_err) err_spurious <= 1'b0;

      if (flush)        err_timeout <= 1'b1;
      else if (clr_err) err_timeout <= 1'b0;

      if (mismatch)     mismatch_cnt <= (cnt_base == 16'hFFFF) ? 16'hFFFF : cnt_base + 16'h0001;
      else if (clr_err) mismatch_cnt <= 16'h0000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_stream_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sync_stream_controller - directed scoreboard bench for the controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sync_stream_controller;

  localparam int XW = 10, YW = 10, CW = 8, RW = 5, GW = 6, BW = 5;
  localparam int DEPTH = 4, TIMEOUT = 8;
  localparam int QW = XW + YW + 3*CW;

  typedef struct packed {
    logic [9:0] x; logic [9:0] y; logic [7:0] r; logic [7:0] g; logic [7:0] b;
  } rec_t;

  typedef struct packed {
    logic [9:0] x; logic [9:0] y;
    logic [4:0] dr; logic [5:0] dg; logic [4:0] db;
    logic [4:0] cr; logic [5:0] cg; logic [4:0] cb;
  } out_t;

  logic clk_25 = 1'b0;
  logic rst, en, clr_err, rdempty, rdreq, start, ready, val;
  logic [QW-1:0] q;
  logic [XW-1:0] query_x, return_x, sync_x;
  logic [YW-1:0] query_y, return_y, sync_y;
  logic [RW-1:0] ret_r, dvi_r, ccd_r;
  logic [GW-1:0] ret_g, dvi_g, ccd_g;
  logic [BW-1:0] ret_b, dvi_b, ccd_b;
  logic [2:0]    outstanding;
  logic err_mismatch, err_spurious, err_timeout;
  logic [15:0] mismatch_cnt;

  sync_stream_controller #(
    .XW(XW), .YW(YW), .CW(CW), .RW(RW), .GW(GW), .BW(BW),
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_25(clk_25), .rst(rst), .en(en), .clr_err(clr_err),
    .q(q), .rdempty(rdempty), .rdreq(rdreq),
    .query_x(query_x), .query_y(query_y), .start(start),
    .ready(ready), .return_x(return_x), .return_y(return_y),
    .r(ret_r), .g(ret_g), .b(ret_b),
    .val(val), .sync_x(sync_x), .sync_y(sync_y),
    .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
    .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b),
    .outstanding(outstanding),
    .err_mismatch(err_mismatch), .err_spurious(err_spurious),
    .err_timeout(err_timeout), .mismatch_cnt(mismatch_cnt)
  );

  always #20 clk_25 = ~clk_25;

  rec_t        fifo [$];
  logic [19:0] qexp [$];
  out_t        oexp [$];
  int errors = 0;
  int checks = 0;
  int vals   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic rec_t mkr(input int x, input int y, input int rr, input int gg, input int bb);
    rec_t t;
    t.x = 10'(x); t.y = 10'(y); t.r = 8'(rr); t.g = 8'(gg); t.b = 8'(bb);
    return t;
  endfunction

  task automatic refresh_fifo();
    rdempty = (fifo.size() == 0);
    q       = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  // One clock; the bench FIFO model pops whatever the DUT requested.
  task automatic tick();
    logic popd;
    @(negedge clk_25);
    popd = rdreq;
    @(posedge clk_25);
    #1;
    if (popd && fifo.size() != 0) begin
      qexp.push_back({fifo[0].x, fifo[0].y});
      fifo.delete(0);
    end
    refresh_fifo();
  endtask

  task automatic ret(input int x, input int y, input int cr, input int cg, input int cb);
    ready = 1'b1;
    return_x = 10'(x); return_y = 10'(y);
    ret_r = 5'(cr); ret_g = 6'(cg); ret_b = 5'(cb);
  endtask

  task automatic expect_out(input int x, input int y, input int dr, input int dg, input int db,
                            input int cr, input int cg, input int cb);
    out_t e;
    e.x = 10'(x); e.y = 10'(y);
    e.dr = 5'(dr); e.dg = 6'(dg); e.db = 5'(db);
    e.cr = 5'(cr); e.cg = 6'(cg); e.cb = 5'(cb);
    oexp.push_back(e);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  always @(negedge clk_25) begin
    if (start) begin
      if (qexp.size() == 0) begin
        checks++; errors++;
        $display("FAIL start_unexpected: got start=1 query %0d,%0d want no start", query_x, query_y);
      end else begin
        check("query_xy", {query_x, query_y}, qexp[0]);
        qexp.delete(0);
      end
    end
    if (val) begin
      vals++;
      if (oexp.size() == 0) begin
        checks++; errors++;
        $display("FAIL val_unexpected: got val=1 sync %0d,%0d want no val", sync_x, sync_y);
      end else begin
        check("out_sync", {sync_x, sync_y}, {oexp[0].x, oexp[0].y});
        check("out_dvi", {dvi_r, dvi_g, dvi_b}, {oexp[0].dr, oexp[0].dg, oexp[0].db});
        check("out_ccd", {ccd_r, ccd_g, ccd_b}, {oexp[0].cr, oexp[0].cg, oexp[0].cb});
        oexp.delete(0);
      end
    end
  end

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: got no finish want finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int due [$];
    int ri, v0, maxo, stalls, n, sim_o;
    bit sim_pend, sim_done;
    rec_t tr;

    rst = 1'b1; en = 1'b0; clr_err = 1'b0; ready = 1'b0;
    return_x = '0; return_y = '0; ret_r = '0; ret_g = '0; ret_b = '0;
    refresh_fifo();
    repeat (3) tick();
    check("reset_ctrl", {start, val, rdreq, outstanding, err_mismatch, err_spurious, err_timeout, mismatch_cnt}, 0);
    check("reset_coords", {query_x, query_y, sync_x, sync_y}, 0);
    check("reset_colours", {dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b}, 0);
    rst = 1'b0; en = 1'b1;
    tick();

    // Single pixel
    fifo.push_back(mkr(5, 7, 8'hF8, 8'hFC, 8'hF8));
    refresh_fifo();
    #1;
    check("t1_rdreq", rdreq, 1);
    tick();
    check("t1_start", start, 1);
    check("t1_outstanding", outstanding, 1);
    repeat (3) tick();
    ret(5, 7, 3, 9, 1);
    expect_out(5, 7, 31, 63, 31, 3, 9, 1);
    tick();
    ready = 1'b0;
    check("t1_val", val, 1);
    tick();
    check("t1_flags", {err_mismatch, err_spurious, err_timeout}, 0);
    check("t1_drained", outstanding, 0);

    // Burst of 8 with returns 4 cycles after each start
    for (int i = 0; i < 8; i++) fifo.push_back(mkr(100 + i, 3*i, i << 3, i << 2, i << 3));
    refresh_fifo();
    v0 = vals; ri = 0; maxo = 0; stalls = 0; sim_pend = 0; sim_done = 0; sim_o = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sim_pend) begin
        check("simul_outstanding", outstanding, sim_o);
        check("simul_start", start, 1);
        check("simul_val", val, 1);
        sim_pend = 0; sim_done = 1;
      end
      if (start) due.push_back(cyc + 4);
      if (due.size() != 0 && due[0] == cyc) begin
        due.delete(0);
        tr = mkr(100 + ri, 3*ri, 0, 0, 0);
        ret(tr.x, tr.y, ri + 1, 2*ri, 31 - ri);
        expect_out(tr.x, tr.y, ri, ri, ri, ri + 1, 2*ri, 31 - ri);
        ri++;
      end else begin
        ready = 1'b0;
      end
      #1;
      if (outstanding > maxo) maxo = outstanding;
      if (!rdempty && !rdreq && outstanding == 3'd4) stalls++;
      if (!sim_done && !sim_pend && rdreq && ready) begin
        sim_pend = 1; sim_o = outstanding;
      end
      tick();
    end
    ready = 1'b0;
    check("burst_peak", maxo, 4);
    check("burst_stall_seen", stalls > 0, 1);
    check("burst_vals", vals - v0, 8);
    check("burst_drained", outstanding, 0);
    check("simul_seen", sim_done, 1);

    // Coordinate mismatch
    fifo.push_back(mkr(10, 20, 8'h08, 8'h04, 8'h08));
    refresh_fifo();
    tick(); tick();
    ret(11, 20, 2, 3, 4);
    expect_out(11, 20, 1, 1, 1, 2, 3, 4);
    tick();
    ready = 1'b0;
    check("mm_flag", err_mismatch, 1);
    check("mm_cnt", mismatch_cnt, 1);
    check("mm_no_spurious", err_spurious, 0);
    pulse_clr();
    check("mm_flag_cleared", err_mismatch, 0);
    check("mm_cnt_cleared", mismatch_cnt, 0);

    // Spurious return with nothing outstanding
    v0 = vals;
    ret(1, 1, 1, 1, 1);
    tick();
    ready = 1'b0;
    tick();
    check("sp_flag", err_spurious, 1);
    check("sp_no_val", vals - v0, 0);
    check("sp_outstanding", outstanding, 0);
    pulse_clr();
    check("sp_flag_cleared", err_spurious, 0);

    // Timeout: two queries, no returns
    fifo.push_back(mkr(1, 1, 0, 0, 0));
    fifo.push_back(mkr(2, 2, 0, 0, 0));
    refresh_fifo();
    tick(); tick();
    repeat (4) tick();
    check("to_not_early", {outstanding, err_timeout}, {3'd2, 1'b0});
    n = 0;
    while (outstanding != 0 && n < 20) begin
      tick();
      n++;
    end
    check("to_flushed", outstanding, 0);
    check("to_latency", n, 4);
    check("to_flag", err_timeout, 1);
    pulse_clr();
    check("to_flag_cleared", err_timeout, 0);
    fifo.push_back(mkr(3, 4, 8'h10, 8'h0C, 8'h18));
    refresh_fifo();
    tick();
    check("to_reissue_start", start, 1);
    tick();
    ret(3, 4, 7, 7, 7);
    expect_out(3, 4, 2, 3, 3, 7, 7, 7);
    tick();
    ready = 1'b0;
    check("to_reissue_val", val, 1);
    check("to_reissue_no_mm", err_mismatch, 0);

    // Reset in the middle of a burst
    for (int i = 0; i < 4; i++) fifo.push_back(mkr(200 + i, i, 0, 0, 0));
    refresh_fifo();
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_ctrl", {start, val, outstanding, err_mismatch, err_spurious, err_timeout, mismatch_cnt}, 0);
    check("rst_coords", {query_x, query_y, sync_x, sync_y}, 0);
    check("rst_colours", {dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b}, 0);
    check("rst_rdreq_held", {rdempty, rdreq}, 2'b00);
    fifo.delete();
    refresh_fifo();
    rst = 1'b0;
    tick();
    v0 = vals;
    ret(200, 0, 1, 1, 1);
    tick();
    ready = 1'b0;
    tick();
    check("rst_late_spurious", err_spurious, 1);
    check("rst_late_no_val", vals - v0, 0);

    tick();
    check("sb_query_empty", qexp.size(), 0);
    check("sb_out_empty", oexp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
